// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester and VRAM-pin bundle for the VRAM arbiter
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  disp_req;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  disp_ack;
  logic [DATA_WIDTH-1:0] disp_rdata;
  logic                  mpu_req;
  logic                  mpu_wr;
  logic [1:0]            mpu_be;
  logic [ADDR_WIDTH-1:0] mpu_addr;
  logic [DATA_WIDTH-1:0] mpu_wdata;
  logic                  mpu_ack;
  logic [DATA_WIDTH-1:0] mpu_rdata;
  logic                  vram_en;
  logic                  vram_rd;
  logic                  vram_wr;
  logic [1:0]            vram_be;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_data_out;
  logic [DATA_WIDTH-1:0] vram_data_in;
  modport master (
    output disp_req, disp_addr, mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata, vram_data_in,
    input  disp_ack, disp_rdata, mpu_ack, mpu_rdata,
    input  vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
  );
  modport slave (
    input  disp_req, disp_addr, mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata, vram_data_in,
    output disp_ack, disp_rdata, mpu_ack, mpu_rdata,
    output vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: display/MPU time-multiplexer for the VRAM port; define VRAM_ARB_STARVE_GUARD_EN to let a waiting MPU in after MPU_MAX_WAIT display grants
module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MPU_MAX_WAIT  = 4
) (
  input logic            clk,
  input logic            _reset,
  vram_arbiter_if.slave  bus
);
  localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  own, own_d;
  logic                  mpu_pick;
  logic                  en_d, rd_d, wr_d, dack_d, mack_d;
  logic [1:0]            be_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] dout_d, drd_d, mrd_d;
  if (ACCESS_CYCLES < 1 || MPU_MAX_WAIT < 0) begin : g_bad_params
    $error("vram_arbiter: ACCESS_CYCLES must be >= 1 and MPU_MAX_WAIT >= 0");
  end
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MPU_MAX_WAIT + 2);
  logic [WW-1:0] wait_cnt, wait_d;
  assign mpu_pick = bus.mpu_req && (!bus.disp_req || wait_cnt == WW'(MPU_MAX_WAIT));
  // counts display grants that overtook a waiting MPU; cleared when the MPU wins or stops asking
  always_comb begin
    wait_d = state != IDLE ? wait_cnt :
             (!bus.mpu_req || mpu_pick) ? '0 :
             bus.disp_req ? wait_cnt + 1'b1 : wait_cnt;
  end
  // wait counter register
  always_ff @(posedge clk) begin
    if (!_reset) wait_cnt <= '0;
    else wait_cnt <= wait_d;
  end
`else
  assign mpu_pick = bus.mpu_req && !bus.disp_req;
`endif
  // next-state and next-output logic; every output is registered, so grant decisions show up one edge later
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    own_d   = own;
    en_d    = bus.vram_en;
    rd_d    = bus.vram_rd;
    wr_d    = bus.vram_wr;
    be_d    = bus.vram_be;
    addr_d  = bus.vram_addr;
    dout_d  = bus.vram_data_out;
    drd_d   = bus.disp_rdata;
    mrd_d   = bus.mpu_rdata;
    dack_d  = 1'b0;
    mack_d  = 1'b0;
    case (state)
      IDLE: if (bus.disp_req || bus.mpu_req) begin
        state_d = ACCESS;
        cnt_d   = CW'(ACCESS_CYCLES - 1);
        own_d   = mpu_pick;
        en_d    = 1'b1;
        rd_d    = mpu_pick ? !bus.mpu_wr : 1'b1;
        wr_d    = mpu_pick && bus.mpu_wr;
        be_d    = mpu_pick ? bus.mpu_be : 2'b11;
        addr_d  = mpu_pick ? bus.mpu_addr : bus.disp_addr;
        dout_d  = mpu_pick ? bus.mpu_wdata : bus.vram_data_out;
      end
      ACCESS: if (cnt == '0) begin
        state_d = DONE;
        en_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        drd_d   = (bus.vram_rd && !own) ? bus.vram_data_in : bus.disp_rdata;
        mrd_d   = (bus.vram_rd && own) ? bus.vram_data_in : bus.mpu_rdata;
        dack_d  = !own;
        mack_d  = own;
      end else begin
        cnt_d = cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset also aborts any access in flight without an ack
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state             <= IDLE;
      cnt               <= '0;
      own               <= 1'b0;
      bus.vram_en       <= 1'b0;
      bus.vram_rd       <= 1'b0;
      bus.vram_wr       <= 1'b0;
      bus.vram_be       <= '0;
      bus.vram_addr     <= '0;
      bus.vram_data_out <= '0;
      bus.disp_rdata    <= '0;
      bus.mpu_rdata     <= '0;
      bus.disp_ack      <= 1'b0;
      bus.mpu_ack       <= 1'b0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      own               <= own_d;
      bus.vram_en       <= en_d;
      bus.vram_rd       <= rd_d;
      bus.vram_wr       <= wr_d;
      bus.vram_be       <= be_d;
      bus.vram_addr     <= addr_d;
      bus.vram_data_out <= dout_d;
      bus.disp_rdata    <= drd_d;
      bus.mpu_rdata     <= mrd_d;
      bus.disp_ack      <= dack_d;
      bus.mpu_ack       <= mack_d;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scoreboard bench for vram_arbiter (ACCESS_CYCLES=2, MPU_MAX_WAIT=4)
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic [15:0] exp_disp[$];
  logic [15:0] exp_mpu[$];
  logic [15:0] mpu_model = '0;
  vram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
  vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ACCESS_CYCLES(2), .MPU_MAX_WAIT(4)) dut (
    .clk(clk), ._reset(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input bit mpu);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!(mpu ? bus.mpu_ack : bus.disp_ack) && i < 20);
    chk(tag, 32'(mpu ? bus.mpu_ack : bus.disp_ack), 1);
  endtask

  task automatic do_mpu(input string tag, input bit wr, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdval);
    bus.mpu_req = 1'b1; bus.mpu_wr = wr; bus.mpu_be = be; bus.mpu_addr = addr;
    bus.mpu_wdata = wdata; bus.vram_data_in = rdval;
    if (!wr) mpu_model = rdval;
    exp_mpu.push_back(mpu_model);
    wait_ack(tag, 1'b1);
    bus.mpu_req = 1'b0;
    tick();
  endtask

  task automatic do_disp(input string tag, input logic [15:0] addr, input logic [15:0] rdval);
    bus.disp_req = 1'b1; bus.disp_addr = addr; bus.vram_data_in = rdval;
    exp_disp.push_back(rdval);
    wait_ack(tag, 1'b0);
    bus.disp_req = 1'b0;
    tick();
  endtask

  // scoreboard: every ack must match the oldest expectation queued for that requester
  always @(negedge clk) begin
    if (bus.disp_ack) begin
      chk("disp_ack_pending", 32'(exp_disp.size() > 0), 1);
      if (exp_disp.size() > 0) chk("disp_rdata", bus.disp_rdata, exp_disp.pop_front());
    end
    if (bus.mpu_ack) begin
      chk("mpu_ack_pending", 32'(exp_mpu.size() > 0), 1);
      if (exp_mpu.size() > 0) chk("mpu_rdata", bus.mpu_rdata, exp_mpu.pop_front());
    end
  end

  initial begin
    int k;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0040; bus.mpu_req = 1'b0; bus.mpu_wr = 1'b0;
    bus.mpu_be = 2'b00; bus.mpu_addr = '0; bus.mpu_wdata = '0; bus.vram_data_in = 16'hA5A5;
    repeat (3) tick();
    chk("reset_ctrl", {bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_be, bus.disp_ack, bus.mpu_ack}, 0);
    chk("reset_addr_dout", {bus.vram_addr, bus.vram_data_out}, 0);
    chk("reset_rdata", {bus.disp_rdata, bus.mpu_rdata}, 0);
    exp_disp.push_back(16'hA5A5);
    rst_n = 1'b1;
    tick();
    chk("disp_grant", {bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_be}, 5'b1_1_0_11);
    chk("disp_addr", bus.vram_addr, 16'h0040);
    wait_ack("disp_first_ack", 1'b0);
    chk("disp_done_bus", {bus.vram_en, bus.vram_rd, bus.vram_wr}, 0);
    chk("disp_keeps_mpu_rdata", bus.mpu_rdata, 0);
    bus.disp_req = 1'b0;
    tick();
    chk("disp_ack_single", {bus.disp_ack, bus.vram_en}, 0);
    bus.mpu_req = 1'b1; bus.mpu_wr = 1'b1; bus.mpu_be = 2'b01; bus.mpu_addr = 16'h1234; bus.mpu_wdata = 16'hBEEF;
    exp_mpu.push_back(mpu_model);
    tick();
    chk("wr_c1_ctrl", {bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_be, bus.mpu_ack}, 6'b1_0_1_01_0);
    chk("wr_c1_addr_data", {bus.vram_addr, bus.vram_data_out}, {16'h1234, 16'hBEEF});
    bus.mpu_addr = 16'hFFFF; bus.mpu_wdata = 16'h0000; bus.mpu_be = 2'b10; bus.mpu_wr = 1'b0;
    tick();
    chk("wr_c2_ctrl", {bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_be, bus.mpu_ack}, 6'b1_0_1_01_0);
    chk("wr_c2_latched", {bus.vram_addr, bus.vram_data_out}, {16'h1234, 16'hBEEF});
    tick();
    chk("wr_done", {bus.vram_en, bus.vram_rd, bus.vram_wr, bus.mpu_ack}, 4'b0001);
    bus.mpu_req = 1'b0;
    tick();
    chk("wr_idle", {bus.vram_en, bus.mpu_ack}, 0);
    bus.mpu_req = 1'b1; bus.mpu_wr = 1'b1; bus.mpu_be = 2'b00; bus.mpu_addr = 16'h0010; bus.mpu_wdata = 16'h5555;
    exp_mpu.push_back(mpu_model);
    tick();
    chk("be0_grant", {bus.vram_en, bus.vram_wr, bus.vram_be}, 4'b1_1_00);
    wait_ack("be0_ack", 1'b1);
    bus.mpu_req = 1'b0;
    tick();
    do_mpu("mpu_read_ack", 1'b0, 2'b11, 16'h0100, 16'h0, 16'h1111);
    do_mpu("mpu_write_keeps_rdata", 1'b1, 2'b11, 16'h0101, 16'h7777, 16'hDEAD);
    do_disp("disp_read_ack", 16'h0042, 16'h6666);
    chk("mpu_rdata_after_disp", bus.mpu_rdata, 16'h1111);
    bus.mpu_req = 1'b1; bus.mpu_wr = 1'b0; bus.mpu_be = 2'b11; bus.mpu_addr = 16'h0200; bus.vram_data_in = 16'h2222;
    tick();
    tick();
    chk("abort_in_access", {bus.vram_en, bus.vram_rd}, 2'b11);
    rst_n = 1'b0; bus.mpu_req = 1'b0;
    tick();
    chk("abort_bus", {bus.vram_en, bus.vram_rd, bus.mpu_ack, bus.mpu_rdata}, 0);
    mpu_model = '0;
    rst_n = 1'b1;
    tick();
    chk("abort_no_ack", {bus.vram_en, bus.mpu_ack}, 0);
    do_mpu("after_abort_read", 1'b0, 2'b11, 16'h0300, 16'h0, 16'h4444);
    bus.vram_data_in = 16'h3333; bus.mpu_wr = 1'b0; bus.mpu_addr = 16'h0400; bus.disp_addr = 16'h0500;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    repeat (80) exp_disp.push_back(16'h3333);
    repeat (20) exp_mpu.push_back(16'h3333);
`else
    repeat (100) exp_disp.push_back(16'h3333);
    exp_mpu.push_back(16'h3333);
`endif
    mpu_model = 16'h3333;
    bus.disp_req = 1'b1; bus.mpu_req = 1'b1;
    k = 0;
    for (int c = 0; c < 1000 && k < 100; c++) begin
      tick();
      if (bus.disp_ack || bus.mpu_ack) begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("contend_owner", {bus.disp_ack, bus.mpu_ack}, (k % 5 == 4) ? 2'b01 : 2'b10);
`else
        chk("contend_owner", {bus.disp_ack, bus.mpu_ack}, 2'b10);
`endif
        k++;
      end
    end
    chk("contend_acks", k, 100);
    bus.disp_req = 1'b0;
`ifndef VRAM_ARB_STARVE_GUARD_EN
    wait_ack("mpu_after_disp_stops", 1'b1);
`endif
    bus.mpu_req = 1'b0;
    repeat (3) tick();
    chk("disp_queue_drained", exp_disp.size(), 0);
    chk("mpu_queue_drained", exp_mpu.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
